// File: rtl/sprite_line_buffer_pkg.sv
// Shared types for the sprite line buffer: default geometry, the stored
// per-pixel entry and the fill-side state encoding.
package linebuf_pkg;

    localparam int LB_LINE_W = 640;
    localparam int LB_IDX_W  = 4;

    // One stored pixel: background flag plus the selected colour index.
    typedef struct packed {
        logic                is_bg;
        logic [LB_IDX_W-1:0] idx;
    } lb_entry_t;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } fill_state_t;

endpackage

// File: rtl/sprite_line_buffer_if.sv
// Write-side handshake between the SRAM fetch stage (master) and the
// line buffer (slave).
interface sprite_line_buffer_if #(
    parameter int IDX_W = linebuf_pkg::LB_IDX_W
);
    logic             wr_valid;
    logic             wr_ready;
    logic [9:0]       wr_x;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] wr_back_idx;
    logic             wr_bg;
    logic             wr_line_done;

    modport master (
        output wr_valid, wr_x, wr_idx, wr_back_idx, wr_bg, wr_line_done,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_x, wr_idx, wr_back_idx, wr_bg, wr_line_done,
        output wr_ready
    );
endinterface

// File: rtl/sprite_line_buffer_bank.sv
// One line bank: single write port, single synchronous read port.
// Contents are never reset.
module linebuf_bank
    import linebuf_pkg::*;
#(
    parameter int DEPTH = LB_LINE_W,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  lb_entry_t     wdata_i,
    input  logic [AW-1:0] raddr_i,
    output lb_entry_t     rdata_o
);

    lb_entry_t mem_q [DEPTH];

    // Write the addressed entry and register the read data (read-before-write).
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/sprite_line_buffer.sv
// Ping-pong scanline buffer between the sprite/background fetch stage and
// the palette mapper. bank_sel picks the display bank; the other bank fills.
// Optional macro LINEBUF_UNDERRUN_CNT_EN enables the saturating underrun
// counter; otherwise underrun_cnt reads as zero.
module sprite_line_buffer
    import linebuf_pkg::*;
#(
    parameter int LINE_W = LB_LINE_W,
    parameter int IDX_W  = LB_IDX_W
) (
    input  logic                 Clk,
    input  logic                 Reset,
    sprite_line_buffer_if.slave  wr,
    input  logic [9:0]           drawX,
    input  logic [9:0]           drawY,
    output logic [IDX_W-1:0]     pix_idx,
    output logic                 pix_is_bg,
    output logic                 pix_valid,
    output logic [15:0]          underrun_cnt
);

    localparam logic [9:0] LINE_W_C = 10'(LINE_W);

    fill_state_t state_q;
    logic        bank_sel_q;
    logic [9:0]  drawY_q;
    logic        rd_sel_q;
    logic        rd_oob_q;

    logic        new_line;
    logic        swap;
    logic        wr_en;
    logic        rd_oob;
    logic [9:0]  rd_addr;
    lb_entry_t   wr_entry;
    lb_entry_t   rd_data0;
    lb_entry_t   rd_data1;
    lb_entry_t   rd_entry;

    assign wr.wr_ready    = (state_q == FILL);
    assign wr_en          = wr.wr_valid && wr.wr_ready && (wr.wr_x < LINE_W_C);
    assign wr_entry.is_bg = wr.wr_bg;
    assign wr_entry.idx   = wr.wr_bg ? wr.wr_back_idx : wr.wr_idx;

    // A line change swaps only if the fill side has finished (or finishes now).
    assign new_line = (drawY != drawY_q);
    assign swap     = new_line && ((state_q == FULL) || wr.wr_line_done);

    // Out-of-line columns read a harmless address; the output is masked anyway.
    assign rd_oob  = (drawX >= LINE_W_C);
    assign rd_addr = rd_oob ? '0 : drawX;

    linebuf_bank #(.DEPTH(LINE_W), .AW(10)) u_bank0 (
        .clk     (Clk),
        .we_i    (wr_en && bank_sel_q),
        .waddr_i (wr.wr_x),
        .wdata_i (wr_entry),
        .raddr_i (rd_addr),
        .rdata_o (rd_data0)
    );

    linebuf_bank #(.DEPTH(LINE_W), .AW(10)) u_bank1 (
        .clk     (Clk),
        .we_i    (wr_en && !bank_sel_q),
        .waddr_i (wr.wr_x),
        .wdata_i (wr_entry),
        .raddr_i (rd_addr),
        .rdata_o (rd_data1)
    );

    // Fill FSM, bank selection and line-change tracking.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= FILL;
            bank_sel_q <= 1'b0;
            drawY_q    <= '0;
        end else begin
            drawY_q <= drawY;
            if (new_line) begin
                if (swap) begin
                    bank_sel_q <= ~bank_sel_q;
                    state_q    <= FILL;
                end
            end else if ((state_q == FILL) && wr.wr_line_done) begin
                state_q <= FULL;
            end
        end
    end

    // Read pipeline: remember which bank and whether the column was in range.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rd_sel_q <= 1'b0;
            rd_oob_q <= 1'b1;
        end else begin
            rd_sel_q <= bank_sel_q;
            rd_oob_q <= rd_oob;
        end
    end

    assign rd_entry  = rd_sel_q ? rd_data1 : rd_data0;
    assign pix_valid = ~rd_oob_q;
    assign pix_idx   = rd_oob_q ? '0 : rd_entry.idx;
    assign pix_is_bg = rd_oob_q | rd_entry.is_bg;

`ifdef LINEBUF_UNDERRUN_CNT_EN
    logic [15:0] underrun_q;
    logic [15:0] underrun_d;

    assign underrun_d = (new_line && !swap && (underrun_q != 16'hFFFF))
                        ? underrun_q + 16'd1 : underrun_q;

    // Saturating count of lines that had to be redisplayed.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            underrun_q <= '0;
        end else begin
            underrun_q <= underrun_d;
        end
    end

    assign underrun_cnt = underrun_q;
`else
    assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_sprite_line_buffer.sv
// Self-checking bench for sprite_line_buffer: directed scenarios followed by
// randomized traffic against a behavioural two-bank model.
module tb_sprite_line_buffer;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [9:0]  drawX = '0;
    logic [9:0]  drawY = '0;
    logic [3:0]  pix_idx;
    logic        pix_is_bg;
    logic        pix_valid;
    logic [15:0] underrun_cnt;

    sprite_line_buffer_if #(.IDX_W(4)) wif ();

    sprite_line_buffer #(.LINE_W(640), .IDX_W(4)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .wr           (wif),
        .drawX        (drawX),
        .drawY        (drawY),
        .pix_idx      (pix_idx),
        .pix_is_bg    (pix_is_bg),
        .pix_valid    (pix_valid),
        .underrun_cnt (underrun_cnt)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    // Model: two physical line banks, which one is on display, fill status.
    logic [4:0]  mm [2][640];
    bit          mk [2][640];
    bit          m_sel;
    bit          m_full;
    logic [9:0]  m_drawY;
    logic [15:0] m_ucnt;

    logic        exp_known;
    logic        exp_valid;
    logic        exp_bg;
    logic [3:0]  exp_idx;

    function automatic logic [15:0] exp_ucnt();
`ifdef LINEBUF_UNDERRUN_CNT_EN
        return m_ucnt;
`else
        return 16'd0;
`endif
    endfunction

    task automatic model_reset();
        m_sel   = 1'b0;
        m_full  = 1'b0;
        m_drawY = '0;
        m_ucnt  = '0;
    endtask

    task automatic idle_inputs();
        wif.wr_valid     = 1'b0;
        wif.wr_line_done = 1'b0;
        wif.wr_x         = '0;
        wif.wr_idx       = '0;
        wif.wr_back_idx  = '0;
        wif.wr_bg        = 1'b0;
    endtask

    // Predict this cycle's read, apply the cycle to the model, advance one clock.
    task automatic cyc();
        int         a;
        logic [4:0] e;
        int         fb;
        if (drawX >= 10'd640) begin
            exp_known = 1'b1; exp_valid = 1'b0; exp_idx = 4'h0; exp_bg = 1'b1;
        end else begin
            a = int'(drawX);
            e = mm[m_sel][a];
            exp_known = mk[m_sel][a];
            exp_valid = 1'b1;
            exp_bg    = e[4];
            exp_idx   = e[3:0];
        end
        fb = m_sel ? 0 : 1;
        if (wif.wr_valid && !m_full && (wif.wr_x < 10'd640)) begin
            mm[fb][int'(wif.wr_x)] = {wif.wr_bg, wif.wr_bg ? wif.wr_back_idx : wif.wr_idx};
            mk[fb][int'(wif.wr_x)] = 1'b1;
        end
        if (drawY != m_drawY) begin
            if (m_full || wif.wr_line_done) begin
                m_sel  = ~m_sel;
                m_full = 1'b0;
            end else if (m_ucnt != 16'hFFFF) begin
                m_ucnt = m_ucnt + 16'd1;
            end
        end else if (wif.wr_line_done && !m_full) begin
            m_full = 1'b1;
        end
        m_drawY = drawY;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        drawX = '0;
        drawY = '0;
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        model_reset();
        total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL reset_pix_valid got=%0b want=0", pix_valid); end
        total++; if (pix_idx !== 4'h0) begin bad++; $display("FAIL reset_pix_idx got=%0h want=0", pix_idx); end
        total++; if (pix_is_bg !== 1'b1) begin bad++; $display("FAIL reset_pix_is_bg got=%0b want=1", pix_is_bg); end
        total++; if (wif.wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready got=%0b want=1", wif.wr_ready); end
        total++; if (underrun_cnt !== 16'd0) begin bad++; $display("FAIL reset_underrun got=%0d want=0", underrun_cnt); end
        Reset = 1'b0;
        cyc();
    endtask

    task automatic test_fill_sweep();
        for (int x = 0; x < 640; x++) begin
            wif.wr_valid    = 1'b1;
            wif.wr_x        = 10'(x);
            wif.wr_idx      = 4'(x);
            wif.wr_bg       = 1'b0;
            wif.wr_back_idx = 4'($urandom);
            cyc();
        end
        idle_inputs();
        wif.wr_line_done = 1'b1;
        cyc();
        wif.wr_line_done = 1'b0;
        total++; if (wif.wr_ready !== 1'b0) begin bad++; $display("FAIL full_wr_ready got=%0b want=0", wif.wr_ready); end
        drawY = 10'd1;
        cyc();
        total++; if (wif.wr_ready !== 1'b1) begin bad++; $display("FAIL swap_wr_ready got=%0b want=1", wif.wr_ready); end
        for (int x = 0; x < 640; x++) begin
            drawX = 10'(x);
            cyc();
            total++;
            if (pix_idx !== 4'(x) || pix_is_bg !== 1'b0 || pix_valid !== 1'b1) begin
                bad++;
                $display("FAIL sweep_x%0d got idx=%0h bg=%0b v=%0b want idx=%0h bg=0 v=1",
                         x, pix_idx, pix_is_bg, pix_valid, 4'(x));
            end
        end
    endtask

    task automatic test_bg_select();
        wif.wr_valid = 1'b1; wif.wr_x = 10'd5; wif.wr_bg = 1'b1;
        wif.wr_back_idx = 4'hA; wif.wr_idx = 4'h3;
        cyc();
        idle_inputs();
        wif.wr_line_done = 1'b1;
        cyc();
        wif.wr_line_done = 1'b0;
        drawY = 10'd2;
        cyc();
        drawX = 10'd5;
        cyc();
        total++;
        if (pix_idx !== 4'hA || pix_is_bg !== 1'b1 || pix_valid !== 1'b1) begin
            bad++;
            $display("FAIL bg_select got idx=%0h bg=%0b v=%0b want idx=a bg=1 v=1", pix_idx, pix_is_bg, pix_valid);
        end
    endtask

    task automatic test_underrun();
        logic [15:0] want;
`ifdef LINEBUF_UNDERRUN_CNT_EN
        want = 16'd1;
`else
        want = 16'd0;
`endif
        drawY = 10'd3;
        drawX = 10'd5;
        cyc();
        cyc();
        total++;
        if (pix_idx !== 4'hA || pix_is_bg !== 1'b1) begin
            bad++;
            $display("FAIL underrun_repeat got idx=%0h bg=%0b want idx=a bg=1", pix_idx, pix_is_bg);
        end
        total++; if (underrun_cnt !== want) begin bad++; $display("FAIL underrun_cnt got=%0d want=%0d", underrun_cnt, want); end
        total++; if (wif.wr_ready !== 1'b1) begin bad++; $display("FAIL underrun_wr_ready got=%0b want=1", wif.wr_ready); end
    endtask

    task automatic test_same_cycle_swap();
        wif.wr_valid = 1'b1; wif.wr_x = 10'd7; wif.wr_idx = 4'hC; wif.wr_bg = 1'b0;
        wif.wr_line_done = 1'b1;
        drawY = 10'd4;
        cyc();
        idle_inputs();
        drawX = 10'd7;
        cyc();
        total++;
        if (pix_idx !== 4'hC || pix_is_bg !== 1'b0 || pix_valid !== 1'b1) begin
            bad++;
            $display("FAIL same_cycle_swap got idx=%0h bg=%0b v=%0b want idx=c bg=0 v=1", pix_idx, pix_is_bg, pix_valid);
        end
    endtask

    task automatic test_full_and_oob();
        wif.wr_valid = 1'b1; wif.wr_x = 10'd3; wif.wr_idx = 4'h2; wif.wr_bg = 1'b0;
        cyc();
        idle_inputs();
        wif.wr_line_done = 1'b1;
        cyc();
        wif.wr_line_done = 1'b0;
        wif.wr_valid = 1'b1; wif.wr_x = 10'd3; wif.wr_idx = 4'hF;
        for (int i = 0; i < 3; i++) begin
            cyc();
            total++; if (wif.wr_ready !== 1'b0) begin bad++; $display("FAIL full_hold_ready_%0d got=%0b want=0", i, wif.wr_ready); end
        end
        idle_inputs();
        drawY = 10'd5;
        cyc();
        drawX = 10'd3;
        cyc();
        total++; if (pix_idx !== 4'h2) begin bad++; $display("FAIL full_no_write got idx=%0h want=2", pix_idx); end
        total++; if (wif.wr_ready !== 1'b1) begin bad++; $display("FAIL refill_ready got=%0b want=1", wif.wr_ready); end
        wif.wr_valid = 1'b1; wif.wr_x = 10'd700; wif.wr_idx = 4'hF; wif.wr_bg = 1'b1;
        cyc();
        idle_inputs();
        total++; if (wif.wr_ready !== 1'b1) begin bad++; $display("FAIL oob_write_ready got=%0b want=1", wif.wr_ready); end
        cyc();
        total++; if (pix_idx !== 4'h2 || pix_is_bg !== 1'b0) begin bad++; $display("FAIL oob_write_effect got idx=%0h bg=%0b want idx=2 bg=0", pix_idx, pix_is_bg); end
        drawX = 10'd650;
        cyc();
        total++;
        if (pix_valid !== 1'b0 || pix_idx !== 4'h0 || pix_is_bg !== 1'b1) begin
            bad++;
            $display("FAIL oob_read got idx=%0h bg=%0b v=%0b want idx=0 bg=1 v=0", pix_idx, pix_is_bg, pix_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] want;
`ifdef LINEBUF_UNDERRUN_CNT_EN
        want = 16'd1;
`else
        want = 16'd0;
`endif
        wif.wr_line_done = 1'b1;
        drawY = 10'd6;
        cyc();
        wif.wr_line_done = 1'b0;
        for (int x = 0; x < 10; x++) begin
            drawX = 10'(x);
            cyc();
        end
        #1;
        Reset = 1'b1;
        #1;
        total++;
        if (pix_valid !== 1'b0 || pix_idx !== 4'h0 || pix_is_bg !== 1'b1) begin
            bad++;
            $display("FAIL async_reset_pix got idx=%0h bg=%0b v=%0b want idx=0 bg=1 v=0", pix_idx, pix_is_bg, pix_valid);
        end
        total++; if (wif.wr_ready !== 1'b1) begin bad++; $display("FAIL async_reset_ready got=%0b want=1", wif.wr_ready); end
        total++; if (underrun_cnt !== 16'd0) begin bad++; $display("FAIL async_reset_underrun got=%0d want=0", underrun_cnt); end
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        model_reset();
        drawX = 10'd3;
        cyc();
        total++; if (pix_idx !== 4'h2 || pix_valid !== 1'b1) begin bad++; $display("FAIL post_reset_bank0 got idx=%0h v=%0b want idx=2 v=1", pix_idx, pix_valid); end
        total++; if (underrun_cnt !== want) begin bad++; $display("FAIL post_reset_underrun got=%0d want=%0d", underrun_cnt, want); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 4000; n++) begin
            wif.wr_valid     = 1'($urandom_range(0, 1));
            wif.wr_x         = 10'($urandom_range(0, 699));
            wif.wr_idx       = 4'($urandom);
            wif.wr_back_idx  = 4'($urandom);
            wif.wr_bg        = 1'($urandom_range(0, 1));
            wif.wr_line_done = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 29) == 0) drawY = drawY + 10'd1;
            drawX = 10'($urandom_range(0, 660));
            cyc();
            if (exp_known) begin
                total++;
                if (pix_idx !== exp_idx || pix_is_bg !== exp_bg || pix_valid !== exp_valid) begin
                    bad++;
                    $display("FAIL rand_pix_%0d got idx=%0h bg=%0b v=%0b want idx=%0h bg=%0b v=%0b",
                             n, pix_idx, pix_is_bg, pix_valid, exp_idx, exp_bg, exp_valid);
                end
            end
            total++; if (wif.wr_ready !== !m_full) begin bad++; $display("FAIL rand_ready_%0d got=%0b want=%0b", n, wif.wr_ready, !m_full); end
            total++; if (underrun_cnt !== exp_ucnt()) begin bad++; $display("FAIL rand_underrun_%0d got=%0d want=%0d", n, underrun_cnt, exp_ucnt()); end
        end
        idle_inputs();
    endtask

    initial begin
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 640; i++) begin
                mk[b][i] = 1'b0;
                mm[b][i] = '0;
            end
        model_reset();
        test_reset();
        test_fill_sweep();
        test_bg_select();
        test_underrun();
        test_same_cycle_swap();
        test_full_and_oob();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sprite_line_buffer.md
# sprite_line_buffer

Ping-pong line buffer between the SRAM sprite/background fetch stage and the palette/colour mapper. The fetch stage writes the next scanline's 4-bit colour indices, tagged background or sprite, into the fill bank. Meanwhile the display bank is read out at `drawX` for the current line. Banks swap on every `drawY` change, so SRAM traffic is decoupled from the pixel clock.

## Interface
Parameters:
- `LINE_W`, 640: pixels per line held in each bank.
- `IDX_W`, 4: colour-index width.

Ports:
- `Clk`, in, 1: single clock for both the write and read sides.
- `Reset`, in, 1: asynchronous, active-high.
- `wr_valid`, in, 1: the fetch stage presents a pixel.
- `wr_ready`, out, 1: the buffer accepts a pixel this cycle.
- `wr_x`, in, 10: pixel column within the line being filled.
- `wr_idx`, in, `IDX_W`: sprite colour index.
- `wr_back_idx`, in, `IDX_W`: background colour index.
- `wr_bg`, in, 1: pixel is background; selects `wr_back_idx` over `wr_idx`.
- `wr_line_done`, in, 1: single-cycle pulse; the fill of the next line is complete.
- `drawX`, in, 10: current display column.
- `drawY`, in, 10: current display row.
- `pix_idx`, out, `IDX_W`: colour index for the display pixel.
- `pix_is_bg`, out, 1: the display pixel came from the background.
- `pix_valid`, out, 1: `pix_idx` and `pix_is_bg` are meaningful.
- `underrun_cnt`, out, 16: count of line underruns.

## Operation
- Each bank stores `LINE_W` entries of `{is_bg, idx}`. Stored `idx` is `wr_bg ? wr_back_idx : wr_idx`.
- `bank_sel` register: display bank = `bank_sel`, fill bank = `~bank_sel`.
- Fill FSM:
  - FILL: `wr_ready`=1. A handshake (`wr_valid & wr_ready`) with `wr_x < LINE_W` writes the fill bank at `wr_x`. A handshake with `wr_x >= LINE_W` is accepted and discarded. `wr_line_done` moves the FSM to FULL.
  - FULL: `wr_ready`=0. Stays in FULL until a swap.
- Line-change detect: `drawY_q` registers `drawY`. `new_line = (drawY != drawY_q)`.
- On `new_line`:
  - If state is FULL, or `wr_line_done` is asserted this cycle: toggle `bank_sel` and enter FILL.
  - Otherwise (underrun): `bank_sel` holds, so the previous line is redisplayed. The FSM stays in FILL and filling continues. `underrun_cnt` increments.
- A write handshake in the same cycle as a swap lands in the old fill bank, which becomes the display bank.
- Entries not rewritten after a swap retain stale contents. The fetch stage owns full-line coverage.
- Read side: a synchronous read of the display bank at `drawX`. If `drawX >= LINE_W`: `pix_valid`=0, `pix_idx`=0, `pix_is_bg`=1.

## Timing
- Reset values:
  - `bank_sel`=0, FSM=FILL, `drawY_q`=0.
  - `wr_ready`=1 (combinational from FILL).
  - `pix_idx`=0, `pix_is_bg`=1, `pix_valid`=0, `underrun_cnt`=0.
  - Bank contents are not reset.
- Read latency is 1 cycle: outputs in cycle t+1 reflect `drawX` at t, using `bank_sel` as it was at t.
- A swap decided in cycle t affects reads issued in t+1 onward.
- Write latency is 1 cycle. A write to the display bank is impossible except in the same-cycle swap case, which is read-visible from the next cycle.
- `Reset` mid-line: all registers return to reset values immediately, and the next line is treated as an underrun unless a fill completes.
- `underrun_cnt` saturates at 16'hFFFF.

## Configuration
- Macro: `LINEBUF_UNDERRUN_CNT_EN`.
- With the macro defined: the 16-bit saturating underrun counter is implemented.
- Without it: `underrun_cnt` is tied to 0 and the counter register is absent. Underrun behaviour (repeat the previous line) is unchanged.

## Structure
- Package `linebuf_pkg`:
  - `LINE_W`, `IDX_W` defaults.
  - `lb_entry_t` packed struct `{is_bg, idx}`.
  - Fill-state enum: FILL, FULL.
- Sub-module `linebuf_bank`: a one-write, one-synchronous-read RAM of `lb_entry_t`, depth `LINE_W`. It is instantiated twice, with write enable and read select driven by `bank_sel`.

## Test plan
- After reset, write x=0..639 with `idx`=x[3:0], `wr_bg`=0, then pulse `wr_line_done` and step `drawY` 0→1. Sweep `drawX` 0..639 → `pix_idx`=x[3:0] one cycle later, `pix_is_bg`=0, `pix_valid`=1. `wr_ready`=1 after the swap.
- Write x=5 with `wr_bg`=1, `wr_back_idx`=4'hA, `wr_idx`=4'h3, then swap and read `drawX`=5 → `pix_idx`=4'hA, `pix_is_bg`=1.
- Do not assert `wr_line_done` before a `drawY` change → `bank_sel` unchanged, the previous line's values repeat, and `underrun_cnt` goes 0→1 (macro on) or stays 0 (macro off).
- Pulse `wr_line_done` in the same cycle as the `drawY` change, with a write of x=7 `idx`=4'hC → swap occurs and `drawX`=7 reads 4'hC on the line.
- In FULL, hold `wr_valid`=1 → `wr_ready`=0 and no bank change. Write `wr_x`=700 in FILL → accepted, with no bank or output change. Read `drawX`=650 → `pix_valid`=0, `pix_idx`=0.
- Assert `Reset` mid-sweep → outputs reach their reset values asynchronously, and `bank_sel`=0 on release.
